// File: rtl/lms_ctrl_pkg.sv
// Shared state encodings and parameter defaults for the LMS controller and its filter.
package lms_ctrl_pkg;

    localparam int LMS_NB_DATA   = 32;
    localparam int LMS_NTAPS     = 16;
    localparam int LMS_WARMUP    = 1024;
    localparam int LMS_NB_WARMUP = 16;
    localparam int LMS_LATENCY   = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FLUSH  = 3'd1,
        ST_WARMUP = 3'd2,
        ST_ADAPT  = 3'd3,
        ST_FREEZE = 3'd4
    } lms_state_t;

    // States in which a sample pair may be accepted.
    function automatic logic is_streaming(input lms_state_t s);
        return (s == ST_WARMUP) || (s == ST_ADAPT) || (s == ST_FREEZE);
    endfunction

endpackage

// File: rtl/lms_valid_pipe.sv
// Valid/tag delay line: DEPTH registers, bit k carries a tag k+1 cycles old; synchronous clear.
module lms_valid_pipe #(
    parameter int DEPTH = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_tag,
    output logic [DEPTH-1:0] o_tags
);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_tags <= '0;
        end else if (i_clr) begin
            o_tags <= '0;
        end else begin
            o_tags[0] <= i_tag;
            for (int k = 1; k < DEPTH; k++) begin
                o_tags[k] <= o_tags[k-1];
            end
        end
    end

endmodule

// File: rtl/lms_ctrl.sv
// LMS adaptive-filter sequencer: flush, warm-up, adapt/freeze, and error reporting.
// Optional sample monitor port o_samples is enabled by defining LMS_CTRL_MON_EN.
module lms_ctrl
    import lms_ctrl_pkg::*;
#(
    parameter int NB_DATA   = LMS_NB_DATA,
    parameter int NTAPS     = LMS_NTAPS,
    parameter int WARMUP    = LMS_WARMUP,
    parameter int NB_WARMUP = LMS_NB_WARMUP,
    parameter int LATENCY   = LMS_LATENCY
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_clear,
    input  logic               i_freeze,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [NB_DATA-1:0] i_d,
    input  logic [NB_DATA-1:0] i_x,
    output logic               o_fir_en,
    output logic               o_fir_adapt,
    output logic               o_fir_clr,
    output logic [NB_DATA-1:0] o_fir_d,
    output logic [NB_DATA-1:0] o_fir_x,
    input  logic [NB_DATA-1:0] i_fir_e,
    output logic [NB_DATA-1:0] o_e,
    output logic               o_valid,
    output logic [2:0]         o_state
`ifdef LMS_CTRL_MON_EN
    ,
    output logic [31:0]        o_samples
`endif
);

    localparam int NB_FLUSH = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam logic [NB_FLUSH-1:0]  FLUSH_LAST = NB_FLUSH'(NTAPS - 1);
    localparam logic [NB_WARMUP-1:0] WARM_LAST  = (WARMUP > 0) ? NB_WARMUP'(WARMUP - 1) : '0;
    localparam int PIPE_DEPTH = LATENCY + 1;

    // Handshake: a pair transfers on every cycle where i_valid and o_ready are both
    // high; o_ready depends on the state alone, so the source never waits on i_valid.
    lms_state_t            state;
    lms_state_t            state_nxt;
    logic [NB_FLUSH-1:0]   flush_cnt;
    logic [NB_WARMUP-1:0]  warm_cnt;
    logic                  accept;
    logic                  flush_entry;
    logic                  fir_tag;
    logic                  e_load;
    logic [PIPE_DEPTH-1:0] valid_tags;

    assign o_ready = is_streaming(state);
    assign o_state = state;
    assign accept  = i_valid & o_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (i_start) state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (!i_clear && flush_cnt == FLUSH_LAST)
                    state_nxt = (WARMUP == 0) ? ST_ADAPT : ST_WARMUP;
            end
            ST_WARMUP: begin
                if (i_clear)
                    state_nxt = ST_FLUSH;
                else if (accept && warm_cnt == WARM_LAST)
                    state_nxt = i_freeze ? ST_FREEZE : ST_ADAPT;
            end
            ST_ADAPT: begin
                if (i_clear)       state_nxt = ST_FLUSH;
                else if (i_freeze) state_nxt = ST_FREEZE;
            end
            ST_FREEZE: begin
                if (i_clear)        state_nxt = ST_FLUSH;
                else if (!i_freeze) state_nxt = ST_ADAPT;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A clear while already flushing restarts the flush and counts as a fresh entry.
    assign flush_entry = (state_nxt == ST_FLUSH) && ((state != ST_FLUSH) || i_clear);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            flush_cnt   <= '0;
            warm_cnt    <= '0;
            o_fir_en    <= 1'b0;
            o_fir_adapt <= 1'b0;
            o_fir_clr   <= 1'b0;
            o_fir_d     <= '0;
            o_fir_x     <= '0;
            o_e         <= '0;
        end else begin
            state <= state_nxt;

            if (flush_entry)
                flush_cnt <= '0;
            else if (state == ST_FLUSH)
                flush_cnt <= flush_cnt + 1'b1;

            if (flush_entry)
                warm_cnt <= '0;
            else if (state == ST_WARMUP && accept)
                warm_cnt <= warm_cnt + 1'b1;

            // Flush strobes win: a pair accepted in the clear cycle still produces a
            // strobe, but it lands on the first flush cycle with zeroed data.
            if (state_nxt == ST_FLUSH) begin
                o_fir_en    <= 1'b1;
                o_fir_clr   <= 1'b1;
                o_fir_adapt <= 1'b0;
                o_fir_d     <= '0;
                o_fir_x     <= '0;
            end else begin
                o_fir_en    <= accept;
                o_fir_clr   <= 1'b0;
                o_fir_adapt <= accept && (state == ST_ADAPT);
                if (accept) begin
                    o_fir_d <= i_d;
                    o_fir_x <= i_x;
                end
            end

            if (e_load)
                o_e <= i_fir_e;
        end
    end

    assign fir_tag = o_fir_en & ~o_fir_clr;

    lms_valid_pipe #(
        .DEPTH (PIPE_DEPTH)
    ) u_valid_pipe (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (flush_entry),
        .i_tag  (fir_tag),
        .o_tags (valid_tags)
    );

    assign o_valid = valid_tags[LATENCY];

    // o_e captures the filter error in the cycle the tag is LATENCY cycles old.
    generate
        if (LATENCY == 0) begin : g_load_now
            assign e_load = fir_tag;
        end else begin : g_load_tag
            assign e_load = valid_tags[LATENCY-1];
        end
    endgenerate

`ifdef LMS_CTRL_MON_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            o_samples <= '0;
        else if (flush_entry)
            o_samples <= '0;
        else if (o_valid && o_samples != 32'hFFFF_FFFF)
            o_samples <= o_samples + 32'd1;
    end
`endif

endmodule
